alu593_op_sequencer: RTL
========================

Name: alu593_op_sequencer

Overview:
- Command-level sequencer between a requester and the ALU593 datapath plus its data-memory port.
- Accepts one command at a time (opcode from `operation_t` plus two operands) over a valid/ready handshake.
- Issues the command to the ALU or memory port, waits for completion with a timeout watchdog, and returns the result and an error code over a second valid/ready handshake.
- Sits between the instruction front-end and the ALU593 datapath.

Parameters:
- DATA_W, 8, operand width; the result is 2*DATA_W wide to hold `mul_op`.
- TIMEOUT, 16, maximum wait cycles for `alu_done` or `mem_ack` before aborting; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  opcode, encoded as `operation_t`.
- cmd_a  in  DATA_W  operand A; this is the address for `load`/`store`.
- cmd_b  in  DATA_W  operand B; this is the write data for `store`.
- alu_start  out  1  one-cycle pulse that starts the ALU.
- alu_op  out  4  opcode presented to the ALU.
- alu_a, alu_b  out  DATA_W  operands presented to the ALU.
- alu_done  in  1  ALU result valid this cycle.
- alu_result  in  2*DATA_W  ALU result.
- mem_req  out  1  one-cycle pulse that starts a memory access.
- mem_we  out  1  1 = write (`store`), 0 = read (`load`).
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory access complete.
- mem_rdata  in  DATA_W  memory read data.
- res_valid  out  1  response available.
- res_ready  in  1  consumer accepts the response.
- res_data  out  2*DATA_W  result.
- res_err  out  2  error code: 00 ok, 01 illegal opcode, 10 timeout.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs = 0, except cmd_ready, which is 1 in the first cycle after release.
  - Timeout counter = 0.
  - Reset mid-operation aborts the command silently; no response is produced.
- States are IDLE, ISSUE, WAIT_ALU, WAIT_MEM, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch op/a/b into the command register.
    - `no_op`/`no_op1`: go to RESP with res_data = 0, res_err = 00.
    - `rsvd1`..`rsvd5` (4'hA..4'hE): go to RESP with res_data = 0, res_err = 01. No ALU or memory activity.
    - Every other opcode: go to ISSUE.
- cmd_ready is 0 in every state except IDLE, so at most one command is in flight.
- ISSUE (one cycle):
  - `add_op`, `and_op`, `xor_op`, `mul_op`, `sp_func1..3`: alu_start = 1, then go to WAIT_ALU.
  - `load`: mem_req = 1, mem_we = 0, mem_addr = a, then go to WAIT_MEM.
  - `store`: mem_req = 1, mem_we = 1, mem_addr = a, mem_wdata = b, then go to WAIT_MEM.
  - Counter is cleared to 0.
- alu_op/alu_a/alu_b and mem_addr/mem_we/mem_wdata hold the latched values from ISSUE until the command leaves the WAIT state. They are 0 in IDLE.
- WAIT_ALU:
  - The counter increments each cycle.
  - alu_done = 1: capture alu_result into res_data, res_err = 00, go to RESP.
  - Else, if the counter reaches TIMEOUT-1: res_data = 0, res_err = 10, go to RESP.
  - If done and timeout expiry coincide, done wins.
  - alu_done asserted in ISSUE or IDLE is ignored.
- WAIT_MEM: same rules as WAIT_ALU, using mem_ack.
  - `load`: res_data = zero-extended mem_rdata.
  - `store`: res_data = 0.
- Latency from command acceptance to res_valid:
  - Immediate opcodes (`no_op`, `no_op1`, reserved): 1 cycle.
  - ALU/memory opcodes: 2 + k cycles, where k is the number of cycles waited, counting the done/ack cycle.
- RESP:
  - res_valid = 1; res_data and res_err are held stable until res_ready.
  - On res_valid & res_ready: go to IDLE, res_valid drops, cmd_ready = 1 in the next cycle. A new command cannot be accepted in the handshake cycle.
- Width rule: the upper DATA_W bits of res_data are 0 for every opcode except those whose ALU result uses them (`mul_op`); the sequencer passes alu_result through unmodified.

Test Plan:
- Reset, then `add_op` a=8'h12, b=8'h34 with the ALU model returning 16'h0046 after 1 cycle.
  - Expect one alu_start pulse with alu_op = 4'b0001.
  - Expect res_valid 3 cycles after acceptance with res_data = 16'h0046 and res_err = 00.
- `mul_op` a=8'hFF, b=8'hFF with the ALU returning 16'hFE01 after 3 cycles; hold res_ready = 0 for 4 cycles.
  - Expect res_valid held with stable data 16'hFE01 until res_ready.
  - Expect cmd_ready = 0 throughout.
- `rsvd3` (4'hC).
  - Expect no alu_start or mem_req.
  - Expect res_valid the next cycle with res_err = 01 and res_data = 0.
- `load` a=8'h20 with mem_ack after 2 cycles and mem_rdata = 8'hA5.
  - Expect mem_req with mem_we = 0 and mem_addr = 8'h20.
  - Expect res_data = 16'h00A5.
- `store` a=8'h21, b=8'h5A.
  - Expect mem_req with mem_we = 1 and mem_wdata = 8'h5A.
  - Expect res_data = 0.
- `xor_op` with alu_done never asserted and TIMEOUT = 16.
  - Expect res_err = 10 exactly 16 WAIT cycles after ISSUE.
- Repeat the timeout case with alu_done asserted on the last WAIT cycle.
  - Expect res_err = 00.
- Assert rst_n low during WAIT_ALU.
  - Expect all outputs to clear immediately and no response after release.
  - A following `and_op` must complete normally.

Source files
------------

// File: rtl/alu593_op_sequencer.sv
// Command sequencer for the ALU593 datapath: accepts one command, issues it to the
// ALU or data-memory port, waits with a timeout watchdog and returns result + error.
module alu593_op_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [DATA_W-1:0]     cmd_a,
    input  logic [DATA_W-1:0]     cmd_b,

    output logic                  alu_start,
    output logic [3:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic                  alu_done,
    input  logic [2*DATA_W-1:0]   alu_result,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DATA_W-1:0]   res_data,
    output logic [1:0]            res_err
);

    typedef enum logic [3:0] {
        no_op    = 4'h0,
        add_op   = 4'h1,
        and_op   = 4'h2,
        xor_op   = 4'h3,
        mul_op   = 4'h4,
        sp_func1 = 4'h5,
        sp_func2 = 4'h6,
        sp_func3 = 4'h7,
        load     = 4'h8,
        store    = 4'h9,
        rsvd1    = 4'hA,
        rsvd2    = 4'hB,
        rsvd3    = 4'hC,
        rsvd4    = 4'hD,
        rsvd5    = 4'hE,
        no_op1   = 4'hF
    } operation_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ALU,
        WAIT_MEM,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // TIMEOUT is bounded to 255, so an 8-bit wait counter always suffices
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    operation_t            op_q, op_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   res_data_q, res_data_d;
    logic [1:0]            res_err_q, res_err_d;

    function automatic logic is_nop(input operation_t op);
        return (op == no_op) || (op == no_op1);
    endfunction

    function automatic logic is_illegal(input operation_t op);
        return (op >= rsvd1) && (op <= rsvd5);
    endfunction

    function automatic logic is_mem(input operation_t op);
        return (op == load) || (op == store);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= no_op;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= ERR_OK;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d       = operation_t'(cmd_op);
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    res_data_d = '0;
                    res_err_d  = ERR_OK;
                    if (is_nop(operation_t'(cmd_op))) begin
                        state_d = RESP;
                    end else if (is_illegal(operation_t'(cmd_op))) begin
                        res_err_d = ERR_ILLEGAL;
                        state_d   = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = is_mem(op_q) ? WAIT_MEM : WAIT_ALU;
            end

            WAIT_ALU: begin
                cnt_d = cnt_q + 8'd1;
                // completion takes priority over a watchdog expiry in the same cycle
                if (alu_done) begin
                    res_data_d = alu_result;
                    res_err_d  = ERR_OK;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d = '0;
                    res_err_d  = ERR_TIMEOUT;
                    state_d    = RESP;
                end
            end

            WAIT_MEM: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ack) begin
                    res_data_d = (op_q == load) ? {{DATA_W{1'b0}}, mem_rdata} : '0;
                    res_err_d  = ERR_OK;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d = '0;
                    res_err_d  = ERR_TIMEOUT;
                    state_d    = RESP;
                end
            end

            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        alu_start = 1'b0;
        alu_op    = '0;
        alu_a     = '0;
        alu_b     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        res_valid = 1'b0;
        res_data  = '0;
        res_err   = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
            end

            ISSUE, WAIT_ALU, WAIT_MEM: begin
                if (is_mem(op_q)) begin
                    mem_req   = (state_q == ISSUE);
                    mem_we    = (op_q == store);
                    mem_addr  = a_q;
                    mem_wdata = (op_q == store) ? b_q : '0;
                end else begin
                    alu_start = (state_q == ISSUE);
                    alu_op    = op_q;
                    alu_a     = a_q;
                    alu_b     = b_q;
                end
            end

            RESP: begin
                res_valid = 1'b1;
                res_data  = res_data_q;
                res_err   = res_err_q;
            end

            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule
